// File: rtl/bcd_counter_seq.sv
// -----------------------------------------------------------------------------
// bcd_counter_seq
// Binary up/down counter with load, step size and optional saturation, plus a
// sequential double-dabble converter that keeps a registered BCD copy of the
// count. The converter does one add-3/shift step per clock. It restarts on the
// latest count whenever the count has moved since the last conversion.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst        : synchronous active-high reset
//   en         : count enable
//   dir        : 0 = count up, 1 = count down
//   inc        : step magnitude per enabled cycle
//   ld         : load strobe (beats en)
//   ld_val     : load value
//   count_out  : registered binary count
//   bcd        : registered BCD of the last converted count, digit 0 in [3:0]
//   bcd_valid  : bcd currently equals the BCD of count_out
//   busy       : conversion in progress
// -----------------------------------------------------------------------------
module bcd_counter_seq #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3,
   parameter int SAT    = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  dir,
   input  logic [WIDTH-1:0]      inc,
   input  logic                  ld,
   input  logic [WIDTH-1:0]      ld_val,
   output logic [WIDTH-1:0]      count_out,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  bcd_valid,
   output logic                  busy
);

   localparam int STEP_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(WIDTH - 1);

   function automatic longint pow10(input int n);
      longint p;
      p = 1;
      for (int i = 0; i < n; i++) p = p * 10;
      return p;
   endfunction

   // Configuration legality: width range and enough digits for the largest count.
   if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
      $error("bcd_counter_seq: WIDTH must be in 2..16");
   end
   if (pow10(DIGITS) <= ((longint'(1) << WIDTH) - 1)) begin : g_bad_digits
      $error("bcd_counter_seq: DIGITS too small for WIDTH");
   end

   // Up step; the carry out of the WIDTH+1-bit sum flags overflow.
   function automatic logic [WIDTH-1:0] step_up(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
      logic [WIDTH:0] s;
      s = {1'b0, a} + {1'b0, b};
      if ((SAT != 0) && s[WIDTH]) return '1;
      return s[WIDTH-1:0];
   endfunction

   // Down step; the borrow into bit WIDTH flags underflow.
   function automatic logic [WIDTH-1:0] step_down(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
      logic [WIDTH:0] s;
      s = {1'b0, a} - {1'b0, b};
      if ((SAT != 0) && s[WIDTH]) return '0;
      return s[WIDTH-1:0];
   endfunction

   // Double-dabble correction: any digit >= 5 gets +3 before the shift.
   function automatic logic [4*DIGITS-1:0] dabble_adj(input logic [4*DIGITS-1:0] s);
      logic [4*DIGITS-1:0] r;
      r = s;
      for (int i = 0; i < DIGITS; i++) begin
         if (s[4*i +: 4] >= 4'd5) r[4*i +: 4] = s[4*i +: 4] + 4'd3;
      end
      return r;
   endfunction

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [WIDTH-1:0]      r_count;
   logic [WIDTH-1:0]      r_src;
   logic [WIDTH-1:0]      r_shreg;
   logic [4*DIGITS-1:0]   r_scratch;
   logic [4*DIGITS-1:0]   r_bcd;
   logic [STEP_W-1:0]     r_step;
   logic [4*DIGITS-1:0]   w_adj;
   logic                  w_start;
   logic                  w_shift;
   logic                  w_commit;

   // Counter: rst > ld > en.
   always_ff @(posedge clk) begin
      if (rst)     r_count <= '0;
      else if (ld) r_count <= ld_val;
      else if (en) r_count <= dir ? step_down(r_count, inc) : step_up(r_count, inc);
   end

   // Converter state register.
   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   // Converter next state and step strobes.
   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_shift     = 1'b0;
      w_commit    = 1'b0;
      case (r_state)
         IDLE: begin
            if (r_count != r_src) begin
               w_state_nxt = SHIFT;
               w_start     = 1'b1;
            end
         end
         SHIFT: begin
            w_shift = 1'b1;
            if (r_step == LAST_STEP) w_state_nxt = DONE;
         end
         DONE: begin
            w_commit    = 1'b1;
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign w_adj = dabble_adj(r_scratch);

   // Converter datapath. Shift register and scratch need no reset: they are
   // always reloaded on w_start before being used.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_src <= '0;
         r_bcd <= '0;
      end else begin
         if (w_start) begin
            r_src     <= r_count;
            r_shreg   <= r_count;
            r_scratch <= '0;
            r_step    <= '0;
         end else if (w_shift) begin
            {r_scratch, r_shreg} <= {w_adj, r_shreg} << 1;
            r_step               <= r_step + 1'b1;
         end
         if (w_commit) r_bcd <= r_scratch;
      end
   end

   assign count_out = r_count;
   assign bcd       = r_bcd;
   assign busy      = (r_state != IDLE);
   // Built only from registers, so no combinational path from the inputs.
   assign bcd_valid = (r_state == IDLE) && (r_src == r_count);

endmodule

// File: tb/tb_bcd_counter_seq.sv
// -----------------------------------------------------------------------------
// tb_bcd_counter_seq
// Two instances share the stimulus: u_wrap (SAT=0) and u_sat (SAT=1).
// The stimulus pushes the expected BCD result and its completion edge for
// u_wrap into a queue. A monitor pops the queue whenever busy falls.
// -----------------------------------------------------------------------------
module tb_bcd_counter_seq;

   localparam int W    = 8;
   localparam int D    = 3;
   localparam int MAXV = (1 << W) - 1;

   logic          clk = 1'b0;
   logic          rst, en, dir, ld;
   logic [W-1:0]  inc, ld_val;
   logic [W-1:0]  cnt0, cnt1;
   logic [4*D-1:0] bcd0, bcd1;
   logic          vld0, vld1, busy0, busy1;

   always #5 clk = ~clk;

   bcd_counter_seq #(.WIDTH(W), .DIGITS(D), .SAT(0)) u_wrap (
      .clk(clk), .rst(rst), .en(en), .dir(dir), .inc(inc), .ld(ld), .ld_val(ld_val),
      .count_out(cnt0), .bcd(bcd0), .bcd_valid(vld0), .busy(busy0));

   bcd_counter_seq #(.WIDTH(W), .DIGITS(D), .SAT(1)) u_sat (
      .clk(clk), .rst(rst), .en(en), .dir(dir), .inc(inc), .ld(ld), .ld_val(ld_val),
      .count_out(cnt1), .bcd(bcd1), .bcd_valid(vld1), .busy(busy1));

   typedef struct {int bcd; int cyc;} exp_t;
   exp_t q[$];

   int   n_vec = 0;
   int   n_bad = 0;
   int   cyc   = 0;
   bit   mon_on = 1'b0;
   int   m0 = 0;
   int   m1 = 0;
   int   nb;
   int   k;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int bcd_ref(input int v);
      return ((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + (v % 10);
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Scoreboard monitor on u_wrap.
   logic         prev_busy = 1'b0;
   logic [4*D-1:0] prev_bcd = '0;
   exp_t         mon_e;

   always @(negedge clk) begin
      if (mon_on) begin
         if (prev_busy && busy0) chk("bcd_hold", int'(bcd0), int'(prev_bcd));
         if (prev_busy && !busy0) begin
            chk("sb_pending", int'(q.size() > 0), 1);
            if (q.size() > 0) begin
               mon_e = q.pop_front();
               chk("bcd_result", int'(bcd0), mon_e.bcd);
               if (mon_e.cyc >= 0) chk("bcd_latency", cyc, mon_e.cyc);
            end
         end
      end
      prev_busy <= busy0;
      prev_bcd  <= bcd0;
   end

   // Apply one edge of stimulus, update the reference counts, and optionally
   // queue the expected conversion result for u_wrap.
   task automatic op(input bit r, input bit l, input int v, input bit e,
                     input bit d, input int s, input bit push_exp);
      int old0;
      old0   = m0;
      rst    = r;
      ld     = l;
      ld_val = v[W-1:0];
      en     = e;
      dir    = d;
      inc    = s[W-1:0];
      if (r) begin
         m0 = 0; m1 = 0;
      end else if (l) begin
         m0 = v; m1 = v;
      end else if (e) begin
         if (!d) begin
            m0 = (m0 + s) % (MAXV + 1);
            m1 = (m1 + s > MAXV) ? MAXV : m1 + s;
         end else begin
            m0 = (m0 - s + MAXV + 1) % (MAXV + 1);
            m1 = (m1 - s < 0) ? 0 : m1 - s;
         end
      end
      if (push_exp && !r && m0 != old0) q.push_back('{bcd_ref(m0), cyc + 1 + W + 2});
      @(negedge clk);
      rst = 1'b0; ld = 1'b0; en = 1'b0; dir = 1'b0; inc = '0;
      chk("count_wrap", int'(cnt0), m0);
      chk("count_sat", int'(cnt1), m1);
      if (!r && m0 != old0) chk("valid_drop", int'(vld0), 0);
   endtask

   task automatic settle(output int nbusy);
      nbusy = 0;
      repeat (W + 4) begin
         @(negedge clk);
         if (busy0) nbusy++;
      end
      chk("idle_busy", int'(busy0), 0);
      chk("valid_wrap", int'(vld0), 1);
      chk("bcd_wrap_final", int'(bcd0), bcd_ref(m0));
      chk("valid_sat", int'(vld1), 1);
      chk("bcd_sat_final", int'(bcd1), bcd_ref(m1));
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; dir = 1'b0; ld = 1'b0; inc = '0; ld_val = '0;
      repeat (3) @(negedge clk);
      chk("rst_count", int'(cnt0), 0);
      chk("rst_bcd", int'(bcd0), 0);
      chk("rst_busy", int'(busy0), 0);
      chk("rst_valid", int'(vld0), 1);
      chk("rst_count_sat", int'(cnt1), 0);
      chk("rst_valid_sat", int'(vld1), 1);
      rst    = 1'b0;
      mon_on = 1'b1;

      // Single up step: busy for WIDTH+1 cycles, bcd 001 at edge +10.
      op(0, 0, 0, 1, 0, 1, 1);
      settle(nb);
      chk("busy_cycles", nb, W + 1);

      // Load 255, then wrap up to 0 (sat instance holds at 255).
      op(0, 1, 255, 0, 0, 0, 1);
      settle(nb);
      op(0, 0, 0, 1, 0, 1, 1);
      settle(nb);
      chk("busy_cycles_wrap", nb, W + 1);

      // Down from 0: wrap to 255, sat instance 255 -> 254.
      op(0, 0, 0, 1, 1, 1, 1);
      settle(nb);

      // Saturation boundaries with inc=10.
      op(0, 1, 250, 0, 0, 0, 1);
      settle(nb);
      op(0, 0, 0, 1, 0, 10, 1);
      settle(nb);
      op(0, 1, 5, 0, 0, 0, 1);
      settle(nb);
      op(0, 0, 0, 1, 1, 10, 1);
      settle(nb);

      // inc=0 leaves the count alone and starts no conversion.
      op(0, 0, 0, 1, 0, 0, 1);
      settle(nb);
      chk("busy_cycles_inc0", nb, 0);

      // ld beats en.
      op(0, 1, 77, 1, 0, 5, 1);
      settle(nb);

      // Load during a conversion: 037 appears first, then 142.
      op(0, 1, 37, 0, 0, 0, 1);
      k = cyc;
      repeat (2) @(negedge clk);
      q.push_back('{bcd_ref(142), k + 20});
      op(0, 1, 142, 0, 0, 0, 0);
      repeat (7) @(negedge clk);
      chk("transient_bcd", int'(bcd0), 'h037);
      chk("transient_valid", int'(vld0), 0);
      settle(nb);

      // Reset in SHIFT, together with ld and en: no partial bcd write.
      op(0, 1, 200, 0, 0, 0, 0);
      k = cyc;
      @(negedge clk);
      q.push_back('{0, k + 2});
      op(1, 1, 99, 1, 0, 3, 0);
      chk("rst_mid_busy", int'(busy0), 0);
      chk("rst_mid_valid", int'(vld0), 1);
      chk("rst_mid_bcd", int'(bcd0), 0);
      chk("rst_mid_bcd_sat", int'(bcd1), 0);
      chk("rst_mid_busy_sat", int'(busy1), 0);
      settle(nb);

      // Sweep every loadable value.
      for (int v = 0; v <= MAXV; v++) begin
         op(0, 1, v, 0, 0, 0, 1);
         settle(nb);
      end

      repeat (2) @(negedge clk);
      chk("sb_drained", q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/bcd_counter_seq.md
BCD_COUNTER_SEQ -- requirements
Module: bcd_counter_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the binary count width (2..16).
REQ-002 The block SHALL have parameter DIGITS, default 3, giving the BCD digit count; 10^DIGITS > 2^WIDTH-1 is a legal-configuration requirement and is checked by elaboration assertion.
REQ-003 The block SHALL have parameter SAT, default 0, selecting the overflow mode: 0 = modulo wrap, 1 = saturate at 0 / 2^WIDTH-1.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port en, input, 1 bit: count enable.
REQ-007 The block SHALL have port dir, input, 1 bit: 0 = up, 1 = down.
REQ-008 The block SHALL have port inc, input, WIDTH bits: step magnitude applied per enabled cycle.
REQ-009 The block SHALL have port ld, input, 1 bit: load strobe.
REQ-010 The block SHALL have port ld_val, input, WIDTH bits: load value.
REQ-011 The block SHALL have port count_out, output, WIDTH bits: the registered binary count.
REQ-012 The block SHALL have port bcd, output, 4*DIGITS bits: registered BCD of the last converted count, digit 0 in bits [3:0].
REQ-013 The block SHALL have port bcd_valid, output, 1 bit: high when bcd equals the BCD of count_out.
REQ-014 The block SHALL have port busy, output, 1 bit: high while a conversion is in progress.

Function
REQ-015 Counter priority per edge SHALL be rst > ld > en; ld sets count to ld_val; en with ld=0 adds inc (dir=0) or subtracts inc (dir=1).
REQ-016 With SAT=0, arithmetic SHALL be modulo 2^WIDTH (255+1 -> 0 and 0-1 -> 255 for WIDTH=8).
REQ-017 With SAT=1, up-overflow SHALL clamp to 2^WIDTH-1 and down-underflow SHALL clamp to 0; the comparison uses a WIDTH+1-bit result.
REQ-018 inc=0 with en=1 SHALL leave the count unchanged.
REQ-019 The converter SHALL be a sequential double-dabble FSM with states IDLE, SHIFT, DONE and one add-3/shift step per clock.
REQ-020 IDLE SHALL transition to SHIFT when count_out differs from the internal source register src; on that edge src and the shift register load count_out, the BCD scratch clears, and the step counter resets.
REQ-021 SHIFT SHALL perform exactly WIDTH steps: each step adds 3 to every scratch digit that is >= 5, then shifts left by 1 with the source MSB entering.
REQ-022 SHIFT SHALL move to DONE after the WIDTH-th step.
REQ-023 DONE SHALL write the scratch value to bcd and return to IDLE in one cycle.
REQ-024 A count change at edge k SHALL update bcd at edge k+WIDTH+2, a latency of WIDTH+2 cycles (10 for WIDTH=8), when the FSM is IDLE at edge k+1.
REQ-025 Count changes during SHIFT/DONE SHALL NOT abort the conversion; on return to IDLE the FSM restarts with the latest count, so the final bcd always tracks the final count.
REQ-026 busy SHALL equal (state != IDLE).
REQ-027 bcd_valid SHALL equal (state == IDLE) && (src == count_out), with no output glitch from the inputs.
REQ-028 bcd SHALL hold its previous value throughout a conversion.

Reset
REQ-029 On rst=1 at an edge: count_out=0, src=0, bcd=0, state=IDLE, busy=0, bcd_valid=1.
REQ-030 Reset mid-conversion SHALL abandon the conversion with no partial bcd write.
REQ-031 Reset SHALL override simultaneous ld/en.

Verification
REQ-032 Bench case: WIDTH=8, rst, then en=1, inc=1, dir=0 for one cycle -> count_out=1, busy high for 9 cycles, bcd=12'h001 at edge +10, bcd_valid=1.
REQ-033 Bench case: ld=1, ld_val=255, then idle -> bcd=12'h255 after 10 cycles; with SAT=0, en=1, inc=1 gives count_out=0, bcd=12'h000.
REQ-034 Bench case: SAT=1, count=250, inc=10 up -> 255; count=5, inc=10 down -> 0.
REQ-035 Bench case: ld=1, ld_val=37, then ld_val=142 loaded at edge +3 mid-conversion -> bcd transiently 12'h037, final 12'h142, bcd_valid=0 until then.
REQ-036 Bench case: rst asserted during SHIFT -> next cycle bcd=0, busy=0, bcd_valid=1.
REQ-037 Bench case: exhaustive sweep of all 256 loaded values -> bcd matches the decimal reference every time.
